// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers used by the raster timing generator
// and its pixel-pipeline neighbours.
package vga_pkg;

   localparam int unsigned VGA640_H_ACTIVE = 640;
   localparam int unsigned VGA640_H_FP     = 16;
   localparam int unsigned VGA640_H_SYNC   = 96;
   localparam int unsigned VGA640_H_BP     = 48;
   localparam int unsigned VGA640_V_ACTIVE = 480;
   localparam int unsigned VGA640_V_FP     = 10;
   localparam int unsigned VGA640_V_SYNC   = 2;
   localparam int unsigned VGA640_V_BP     = 33;
   localparam int unsigned VGA640_HS_POL   = 0;
   localparam int unsigned VGA640_VS_POL   = 0;

   localparam int unsigned VGA800_H_ACTIVE = 800;
   localparam int unsigned VGA800_H_FP     = 40;
   localparam int unsigned VGA800_H_SYNC   = 128;
   localparam int unsigned VGA800_H_BP     = 88;
   localparam int unsigned VGA800_V_ACTIVE = 600;
   localparam int unsigned VGA800_V_FP     = 1;
   localparam int unsigned VGA800_V_SYNC   = 4;
   localparam int unsigned VGA800_V_BP     = 23;
   localparam int unsigned VGA800_HS_POL   = 1;
   localparam int unsigned VGA800_VS_POL   = 1;

   function automatic int unsigned vga_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   // Bits needed to represent max_value, never less than one.
   function automatic int unsigned vga_width(input int unsigned max_value);
      int unsigned bits;
      bits = $clog2(max_value + 1);
      return (bits == 0) ? 1 : bits;
   endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// W-bit shift register advanced by an enable, with a caller-supplied reset value;
// DLY=0 degenerates to a straight wire.
module sync_delay_line #(
   parameter int unsigned W   = 1,
   parameter int unsigned DLY = 1
) (
   input  logic         CLK,
   input  logic         RES_N,
   input  logic         EN,
   input  logic [W-1:0] RST_VAL,
   input  logic [W-1:0] D,
   output logic [W-1:0] Q
);

   generate
      if (DLY == 0) begin : g_wire
         assign Q = D;
      end else begin : g_pipe
         logic [W-1:0] stage [DLY];

         always_ff @(posedge CLK or negedge RES_N) begin
            if (!RES_N) begin
               for (int i = 0; i < DLY; i++) stage[i] <= RST_VAL;
            end else if (EN) begin
               stage[0] <= D;
               for (int i = 1; i < DLY; i++) stage[i] <= stage[i-1];
            end
         end

         assign Q = stage[DLY-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator driven by a pixel-clock enable, with
// registered coordinates/strobes and a delayed sync/blank path for pipelined sources.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
   parameter int unsigned H_FP     = VGA640_H_FP,
   parameter int unsigned H_SYNC   = VGA640_H_SYNC,
   parameter int unsigned H_BP     = VGA640_H_BP,
   parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
   parameter int unsigned V_FP     = VGA640_V_FP,
   parameter int unsigned V_SYNC   = VGA640_V_SYNC,
   parameter int unsigned V_BP     = VGA640_V_BP,
   parameter int unsigned HS_POL   = VGA640_HS_POL,
   parameter int unsigned VS_POL   = VGA640_VS_POL,
   parameter int unsigned PIPE_DLY = 2,
   parameter int unsigned CW       = 11
) (
   input  logic          CLK,
   input  logic          RES_N,
   input  logic          PIX_EN,
   output logic [CW-1:0] X,
   output logic [CW-1:0] Y,
   output logic          ACTIVE,
   output logic          LINE_START,
   output logic          FRAME_START,
   output logic          HS,
   output logic          VS,
   output logic          DISP
);

   localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          HS_ON    = (HS_POL != 0);
   localparam logic          VS_ON    = (VS_POL != 0);

   generate
      if (CW < vga_width(MAX_TOTAL - 1)) begin : g_cw_check
         $error("vga_timing_gen: CW=%0d cannot hold counter value %0d", CW, MAX_TOTAL - 1);
      end
      if (PIPE_DLY > 15) begin : g_dly_check
         $error("vga_timing_gen: PIPE_DLY=%0d exceeds 15", PIPE_DLY);
      end
   endgenerate

   logic [CW-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
   logic          act_nxt, hs_nxt, vs_nxt;
   logic          hs_reg, vs_reg;
   logic [2:0]    dly_q;

   // Everything registered below describes the counter position after this tick.
   always_comb begin
      h_nxt = h_cnt + CW'(1);
      v_nxt = v_cnt;
      if (h_cnt == H_LAST) begin
         h_nxt = '0;
         v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end
      act_nxt = (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
      hs_nxt  = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? HS_ON : ~HS_ON;
      vs_nxt  = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? VS_ON : ~VS_ON;
   end

   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         h_cnt       <= H_LAST;
         v_cnt       <= V_LAST;
         X           <= '0;
         Y           <= '0;
         ACTIVE      <= 1'b0;
         LINE_START  <= 1'b0;
         FRAME_START <= 1'b0;
         hs_reg      <= ~HS_ON;
         vs_reg      <= ~VS_ON;
      end else if (PIX_EN) begin
         h_cnt       <= h_nxt;
         v_cnt       <= v_nxt;
         X           <= act_nxt ? h_nxt : '0;
         Y           <= act_nxt ? v_nxt : '0;
         ACTIVE      <= act_nxt;
         LINE_START  <= (h_nxt == '0);
         FRAME_START <= (h_nxt == '0) && (v_nxt == '0);
         hs_reg      <= hs_nxt;
         vs_reg      <= vs_nxt;
      end
   end

   sync_delay_line #(
      .W   (3),
      .DLY (PIPE_DLY)
   ) u_sync_delay (
      .CLK     (CLK),
      .RES_N   (RES_N),
      .EN      (PIX_EN),
      .RST_VAL ({~HS_ON, ~VS_ON, 1'b0}),
      .D       ({hs_reg, vs_reg, ACTIVE}),
      .Q       (dly_q)
   );

   assign {HS, VS, DISP} = dly_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a tiny raster in three variants (no delay,
// three-tick delay, inverted polarity) plus the first two lines of default 640x480.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic resN;
   logic pixEn;

   always #5 clk = ~clk;

   logic [10:0] x0, y0, x3, y3, xP, yP, xD, yD;
   logic act0, ls0, fs0, hs0, vs0, disp0;
   logic act3, ls3, fs3, hs3, vs3, disp3;
   logic actP, lsP, fsP, hsP, vsP, dispP;
   logic actD, lsD, fsD, hsD, vsD, dispD;

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(0)) dut0 (
      .CLK(clk), .RES_N(resN), .PIX_EN(pixEn), .X(x0), .Y(y0), .ACTIVE(act0),
      .LINE_START(ls0), .FRAME_START(fs0), .HS(hs0), .VS(vs0), .DISP(disp0));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(3)) dut3 (
      .CLK(clk), .RES_N(resN), .PIX_EN(pixEn), .X(x3), .Y(y3), .ACTIVE(act3),
      .LINE_START(ls3), .FRAME_START(fs3), .HS(hs3), .VS(vs3), .DISP(disp3));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(0),
                    .HS_POL(1), .VS_POL(1)) dutP (
      .CLK(clk), .RES_N(resN), .PIX_EN(pixEn), .X(xP), .Y(yP), .ACTIVE(actP),
      .LINE_START(lsP), .FRAME_START(fsP), .HS(hsP), .VS(vsP), .DISP(dispP));

   vga_timing_gen dutD (
      .CLK(clk), .RES_N(resN), .PIX_EN(pixEn), .X(xD), .Y(yD), .ACTIVE(actD),
      .LINE_START(lsD), .FRAME_START(fsD), .HS(hsD), .VS(vsD), .DISP(dispD));

   int errors = 0;
   int checks = 0;

   // Expected raster position and {hs asserted, vs asserted, active} history.
   int hS, vS, hD, vD;
   logic [2:0] regS, regD;
   logic [2:0] histS [3];
   logic [2:0] histD [2];

   function automatic logic [2:0] decodeSmall(input int hh, input int vv);
      return {(hh >= 10 && hh < 13), (vv >= 5 && vv < 7), (hh < 8 && vv < 4)};
   endfunction

   function automatic logic [2:0] decodeDef(input int hh, input int vv);
      return {(hh >= 656 && hh < 752), (vv >= 490 && vv < 492), (hh < 640 && vv < 480)};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic resetModels();
      hS = 13; vS = 7; hD = 799; vD = 524;
      regS = 3'b000; regD = 3'b000;
      for (int i = 0; i < 3; i++) histS[i] = 3'b000;
      for (int i = 0; i < 2; i++) histD[i] = 3'b000;
   endtask

   // Drive one clock with the given enable; sample on the following falling edge.
   task automatic applyStimulus(input logic en);
      pixEn = en;
      @(posedge clk);
      if (en && resN) begin
         histS[2] = histS[1]; histS[1] = histS[0]; histS[0] = regS;
         if (hS == 13) begin hS = 0; vS = (vS == 7) ? 0 : vS + 1; end else hS++;
         regS = decodeSmall(hS, vS);
         histD[1] = histD[0]; histD[0] = regD;
         if (hD == 799) begin hD = 0; vD = (vD == 524) ? 0 : vD + 1; end else hD++;
         regD = decodeDef(hD, vD);
      end
      @(negedge clk);
   endtask

   task automatic checkSmall();
      logic a;
      a = regS[0];
      checkOutput("x0", x0, a ? hS : 0);
      checkOutput("y0", y0, a ? vS : 0);
      checkOutput("act0", act0, a);
      checkOutput("ls0", ls0, hS == 0);
      checkOutput("fs0", fs0, hS == 0 && vS == 0);
      checkOutput("hs0", hs0, !regS[2]);
      checkOutput("vs0", vs0, !regS[1]);
      checkOutput("disp0", disp0, a);
      checkOutput("hsPol", hsP, regS[2]);
      checkOutput("vsPol", vsP, regS[1]);
      checkOutput("x3", x3, a ? hS : 0);
      checkOutput("hs3", hs3, !histS[2][2]);
      checkOutput("vs3", vs3, !histS[2][1]);
      checkOutput("disp3", disp3, histS[2][0]);
   endtask

   task automatic checkDefault();
      logic a;
      a = regD[0];
      checkOutput("xD", xD, a ? hD : 0);
      checkOutput("yD", yD, a ? vD : 0);
      checkOutput("actD", actD, a);
      checkOutput("lsD", lsD, hD == 0);
      checkOutput("fsD", fsD, hD == 0 && vD == 0);
      checkOutput("hsD", hsD, !histD[1][2]);
      checkOutput("vsD", vsD, !histD[1][1]);
      checkOutput("dispD", dispD, histD[1][0]);
   endtask

   initial begin
      int fsCount, lsCount, actCount, xMax, yMax;
      int fsTimes [$];

      resN = 1'b0;
      pixEn = 1'b0;
      resetModels();
      #22;
      @(negedge clk);
      checkSmall();
      checkDefault();
      checkOutput("resetHsPol", hsP, 0);
      checkOutput("resetVsPol", vsP, 0);

      // One full small frame at full rate.
      resN = 1'b1;
      fsCount = 0; lsCount = 0; actCount = 0; xMax = 0;
      for (int t = 1; t <= 112; t++) begin
         applyStimulus(1'b1);
         checkSmall();
         if (t == 1) begin
            checkOutput("firstFs", fs0, 1);
            checkOutput("firstLs", ls0, 1);
            checkOutput("firstAct", act0, 1);
         end
         if (t <= 3) begin
            checkOutput("earlyDisp3", disp3, 0);
            checkOutput("earlyHs3", hs3, 1);
            checkOutput("earlyVs3", vs3, 1);
         end
         if (t == 4) checkOutput("disp3Rise", disp3, 1);
         if (fs0) fsCount++;
         if (ls0) lsCount++;
         if (act0) actCount++;
         if (act0 && x0 > xMax) xMax = x0;
      end
      checkOutput("fsPerFrame", fsCount, 1);
      checkOutput("linesPerFrame", lsCount, 8);
      checkOutput("activeTicks", actCount, 32);
      checkOutput("xMax", xMax, 7);

      // Enable pattern 1,0,0 repeating: one small frame spans 336 clocks.
      for (int i = 0; i <= 336; i++) begin
         applyStimulus((i % 3) == 0);
         checkSmall();
         if (pixEn && fs0) fsTimes.push_back(i);
      end
      checkOutput("fsCountToggle", fsTimes.size(), 2);
      if (fsTimes.size() == 2)
         checkOutput("fsPeriodClocks", fsTimes[1] - fsTimes[0], 336);

      // Restart, run to (h=5, v=2), then drop reset between clock edges.
      resN = 1'b0;
      resetModels();
      @(negedge clk);
      resN = 1'b1;
      for (int t = 0; t < 34; t++) begin
         applyStimulus(1'b1);
         checkSmall();
      end
      checkOutput("midX", x0, 5);
      checkOutput("midY", y0, 2);
      #2 resN = 1'b0;
      #1;
      resetModels();
      checkSmall();
      checkOutput("asyncX", x0, 0);
      checkOutput("asyncAct", act0, 0);
      applyStimulus(1'b1);
      checkSmall();
      resN = 1'b1;
      applyStimulus(1'b1);
      checkSmall();
      checkOutput("restartFs", fs0, 1);
      checkOutput("restartX", x0, 0);
      checkOutput("restartY", y0, 0);

      // Default 640x480: first two lines.
      resN = 1'b0;
      resetModels();
      @(negedge clk);
      resN = 1'b1;
      lsCount = 0; actCount = 0; xMax = 0; yMax = 0;
      for (int t = 0; t < 1600; t++) begin
         applyStimulus(1'b1);
         checkDefault();
         if (lsD) lsCount++;
         if (actD) actCount++;
         if (xD > xMax) xMax = xD;
         if (yD > yMax) yMax = yD;
      end
      checkOutput("defLines", lsCount, 2);
      checkOutput("defActive", actCount, 1280);
      checkOutput("defXMax", xMax, 639);
      checkOutput("defYMax", yMax, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
